// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register file and its write-back
// arbiter.
//   DW        : register data width
//   AW        : register address width
//   NREGS     : number of architectural registers (2**AW)
//   ZERO_REG  : hard-wired zero register; writes to it are dropped
//   req_id_e  : identifies one of the two write-back requesters
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NREGS    = 1 << AW;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A lone requester is granted at once; when
// both request, the one that was not granted most recently wins. The
// priority pointer only moves when a grant is issued, so idle cycles leave
// it untouched. Grants are suppressed while reset is asserted.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset (pointer favours req0)
//   req0 / req1  : request inputs
//   gnt0 / gnt1  : combinational grants (one-hot or zero)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // Requester that wins the next contested cycle.
    req_id_e favour_reg;
    req_id_e favour_next;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (req0 && req1) begin
                gnt0 = (favour_reg == REQ0);
                gnt1 = (favour_reg == REQ1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // A grant always completes a transfer (grant implies request), so the
    // pointer moves to the other requester whenever anyone is granted.
    always_comb begin
        favour_next = favour_reg;
        if (gnt0) begin
            favour_next = REQ1;
        end else if (gnt1) begin
            favour_next = REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            favour_reg <= REQ0;
        end else begin
            favour_reg <= favour_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates two write-back requesters onto the single register-file write
// port and keeps a busy scoreboard of registers with writes still in flight.
// Ports:
//   clk, rst                     : clock; asynchronous active-low reset
//   reqN_valid/ready/addr/data   : requester N write handshake (N = 0,1)
//   claim_en, claim_addr         : mark a register as pending a future write
//   rs, rt                       : hazard query addresses
//   rs_busy, rt_busy             : query results (combinational)
//   rd, Rd, wen                  : registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
#(
    parameter int DW = regfile_wb_arbiter_pkg::DW,
    parameter int AW = regfile_wb_arbiter_pkg::AW
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] Rd,
    output logic          wen
);

    import regfile_wb_arbiter_pkg::*;

    localparam int NUM_REGS = 1 << AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic gnt0;
    logic gnt1;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    logic          xfer;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_data;

    assign xfer      = gnt0 | gnt1;
    assign xfer_addr = gnt1 ? req1_addr : req0_addr;
    assign xfer_data = gnt1 ? req1_data : req0_data;

    // ------------------------------------------------------------------
    // Output stage: one cycle of latency. Address/data follow every
    // accepted transfer; the enable is dropped for the zero register.
    // ------------------------------------------------------------------
    logic          wen_reg;
    logic [AW-1:0] rd_reg;
    logic [DW-1:0] Rd_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_reg <= 1'b0;
            rd_reg  <= '0;
            Rd_reg  <= '0;
        end else begin
            wen_reg <= xfer && (xfer_addr != ZERO_ADDR);
            if (xfer) begin
                rd_reg <= xfer_addr;
                Rd_reg <= xfer_data;
            end
        end
    end

    assign wen = wen_reg;
    assign rd  = rd_reg;
    assign Rd  = Rd_reg;

    // ------------------------------------------------------------------
    // Busy scoreboard. A bit clears on the edge where its register is
    // committed (wen high with matching rd). A claim on the same edge wins
    // over the commit, because the new claim refers to a later write.
    // The zero register can never be busy.
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == ZERO_REG) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit;
                logic clr_bit;
                assign set_bit = claim_en && (claim_addr == AW'(gi));
                assign clr_bit = wen_reg  && (rd_reg     == AW'(gi));
                assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rs_busy = busy_reg[rs] && (rs != ZERO_ADDR);
    assign rt_busy = busy_reg[rt] && (rt != ZERO_ADDR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed vector table for the documented scenarios, hand-written reset
// sequences, then randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          claim_en;
    logic [AW-1:0] claim_addr;
    logic [AW-1:0] rs, rt;
    logic          rs_busy, rt_busy;
    logic [AW-1:0] rd;
    logic [DW-1:0] Rd;
    logic          wen;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rs         (rs),
        .rt         (rt),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .rd         (rd),
        .Rd         (Rd),
        .wen        (wen)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One row = one clock cycle. Expected values are those seen shortly
    // after the inputs are applied: combinational ready/busy for this
    // cycle, and the registered write port left by the previous edge.
    typedef struct {
        logic [31:0] rstv, v0, v1, a0, a1, d0, d1, ce, ca, rs, rt;
        logic [31:0] er0, er1, ewen, chk_rd, erd, eRd, ers, ert;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = '0;   req1_addr  = '0;
        req0_data  = '0;   req1_data  = '0;
        claim_en   = 1'b0; claim_addr = '0;
        rs         = '0;   rt         = '0;
    endtask

    // Behavioural reference model state.
    logic        m_last1;   // 1 = req1 was granted most recently
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_Rd;
    logic        g0, g1;
    logic [31:0] nb;

    initial begin
        rst = 1'b0;
        clear_inputs();

        //            rst v0 v1 a0 a1 d0   d1            ce ca  rs  rt   r0 r1 wen chk rd  Rd   rsb rtb
        tbl[0]  = '{0, 1, 1, 10, 11, 20, 21,           0, 0,  0,  0,   0, 0, 0, 1, 0,  0,   0, 0};
        tbl[1]  = '{1, 1, 1, 10, 11, 20, 21,           0, 0,  0,  0,   1, 0, 0, 1, 0,  0,   0, 0};
        tbl[2]  = '{1, 1, 1, 10, 11, 20, 21,           0, 0,  0,  0,   0, 1, 1, 1, 10, 20,  0, 0};
        tbl[3]  = '{1, 1, 1, 10, 11, 20, 21,           0, 0,  0,  0,   1, 0, 1, 1, 11, 21,  0, 0};
        tbl[4]  = '{1, 1, 1, 10, 11, 20, 21,           0, 0,  0,  0,   0, 1, 1, 1, 10, 20,  0, 0};
        tbl[5]  = '{1, 0, 0, 10, 11, 20, 21,           0, 0,  0,  0,   0, 0, 1, 1, 11, 21,  0, 0};
        tbl[6]  = '{1, 0, 0, 0,  0,  0,  0,            0, 0,  0,  0,   0, 0, 0, 1, 11, 21,  0, 0};
        tbl[7]  = '{1, 0, 1, 0,  0,  0,  32'hFFFF_FFFF, 0, 0,  0,  0,   0, 1, 0, 1, 11, 21,  0, 0};
        tbl[8]  = '{1, 0, 0, 0,  0,  0,  0,            1, 10, 10, 0,   0, 0, 0, 0, 0,  0,   0, 0};
        tbl[9]  = '{1, 1, 0, 10, 0,  55, 0,            0, 0,  10, 0,   1, 0, 0, 0, 0,  0,   1, 0};
        tbl[10] = '{1, 0, 0, 0,  0,  0,  0,            0, 0,  10, 0,   0, 0, 1, 1, 10, 55,  1, 0};
        tbl[11] = '{1, 0, 0, 0,  0,  0,  0,            0, 0,  10, 0,   0, 0, 0, 1, 10, 55,  0, 0};
        tbl[12] = '{1, 0, 1, 0,  3,  0,  33,           0, 0,  0,  3,   0, 1, 0, 1, 10, 55,  0, 0};
        tbl[13] = '{1, 0, 0, 0,  0,  0,  0,            1, 3,  0,  3,   0, 0, 1, 1, 3,  33,  0, 0};
        tbl[14] = '{1, 0, 0, 0,  0,  0,  0,            0, 0,  0,  3,   0, 0, 0, 1, 3,  33,  0, 1};
        tbl[15] = '{1, 1, 1, 1,  2,  100, 200,         0, 0,  0,  3,   1, 0, 0, 1, 3,  33,  0, 1};
        tbl[16] = '{1, 0, 0, 0,  0,  0,  0,            0, 0,  0,  3,   0, 0, 1, 1, 1,  100, 0, 1};
        tbl[17] = '{1, 0, 0, 0,  0,  0,  0,            1, 0,  0,  3,   0, 0, 0, 1, 1,  100, 0, 1};
        tbl[18] = '{1, 0, 0, 0,  0,  0,  0,            0, 0,  0,  3,   0, 0, 0, 1, 1,  100, 0, 1};

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            rst        = tbl[i].rstv[0];
            req0_valid = tbl[i].v0[0];
            req1_valid = tbl[i].v1[0];
            req0_addr  = tbl[i].a0[AW-1:0];
            req1_addr  = tbl[i].a1[AW-1:0];
            req0_data  = tbl[i].d0;
            req1_data  = tbl[i].d1;
            claim_en   = tbl[i].ce[0];
            claim_addr = tbl[i].ca[AW-1:0];
            rs         = tbl[i].rs[AW-1:0];
            rt         = tbl[i].rt[AW-1:0];
            #1;
            chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), tbl[i].er0);
            chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), tbl[i].er1);
            chk($sformatf("vec%0d_wen", i),    32'(wen),        tbl[i].ewen);
            chk($sformatf("vec%0d_rs_busy", i), 32'(rs_busy),   tbl[i].ers);
            chk($sformatf("vec%0d_rt_busy", i), 32'(rt_busy),   tbl[i].ert);
            if (tbl[i].chk_rd[0]) begin
                chk($sformatf("vec%0d_rd", i), 32'(rd), tbl[i].erd);
                chk($sformatf("vec%0d_Rd", i), Rd,      tbl[i].eRd);
            end
            $display("vec %0d: rdy=%b%b wen=%b rd=%0d Rd=%0h rs_busy=%b rt_busy=%b",
                     i, req0_ready, req1_ready, wen, rd, Rd, rs_busy, rt_busy);
        end

        // Mid-operation reset: a write to 5 is offered (and granted) but
        // reset drops before the edge, so it never reaches the write port.
        @(posedge clk); #1;
        clear_inputs();
        claim_en = 1'b1; claim_addr = 5'd5; rt = 5'd3;
        @(posedge clk); #1;
        clear_inputs();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h5555; rs = 5'd5; rt = 5'd3;
        #1;
        chk("midrst_ready0_before", 32'(req0_ready), 32'd1);
        chk("midrst_rs_busy_before", 32'(rs_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ready0_in_rst", 32'(req0_ready), 32'd0);
        chk("midrst_rs_busy_in_rst", 32'(rs_busy), 32'd0);
        chk("midrst_rt_busy_in_rst", 32'(rt_busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0;
        #1;
        chk("midrst_wen_after", 32'(wen), 32'd0);
        chk("midrst_rs_busy_after", 32'(rs_busy), 32'd0);
        @(posedge clk); #2;
        chk("midrst_wen_after2", 32'(wen), 32'd0);
        $display("seq midrst: wen=%b rs_busy=%b", wen, rs_busy);

        // Reset acts immediately on the registered write port.
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'd77;
        #1;
        chk("async_ready1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("async_wen_pre", 32'(wen), 32'd1);
        chk("async_rd_pre", 32'(rd), 32'd7);
        chk("async_Rd_pre", Rd, 32'd77);
        rst = 1'b0;
        #1;
        chk("async_wen_rst", 32'(wen), 32'd0);
        chk("async_rd_rst", 32'(rd), 32'd0);
        chk("async_Rd_rst", Rd, 32'd0);
        $display("seq async: wen=%b rd=%0d Rd=%0h", wen, rd, Rd);

        // First contested cycle after release goes to req0.
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'd11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'd22;
        #1;
        chk("release_ready0", 32'(req0_ready), 32'd1);
        chk("release_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        #1;
        chk("release_wen", 32'(wen), 32'd1);
        chk("release_rd", 32'(rd), 32'd1);
        chk("release_Rd", Rd, 32'd11);
        $display("seq release: wen=%b rd=%0d Rd=%0h", wen, rd, Rd);

        // Randomized traffic against the reference model. The first cycle
        // is a reset cycle so model and DUT start from the same state.
        m_last1 = 1'b1; m_busy = '0; m_wen = 1'b0; m_rd = '0; m_Rd = '0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            rst        = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_addr  = 5'($urandom_range(0, 7));
            req1_addr  = 5'($urandom_range(0, 7));
            req0_data  = $urandom();
            req1_data  = $urandom();
            claim_en   = ($urandom_range(0, 2) == 0);
            claim_addr = 5'($urandom_range(0, 7));
            rs         = 5'($urandom_range(0, 7));
            rt         = 5'($urandom_range(0, 7));

            if (!rst) begin
                m_last1 = 1'b1; m_busy = '0; m_wen = 1'b0; m_rd = '0; m_Rd = '0;
            end
            g0 = 1'b0; g1 = 1'b0;
            if (rst) begin
                if (req0_valid && req1_valid) begin
                    g0 = m_last1;
                    g1 = !m_last1;
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            #1;
            chk("rnd_ready0", 32'(req0_ready), 32'(g0));
            chk("rnd_ready1", 32'(req1_ready), 32'(g1));
            chk("rnd_wen", 32'(wen), 32'(m_wen));
            chk("rnd_rs_busy", 32'(rs_busy), 32'((rs != 0) && m_busy[rs]));
            chk("rnd_rt_busy", 32'(rt_busy), 32'((rt != 0) && m_busy[rt]));
            if (m_wen || !rst) begin
                chk("rnd_rd", 32'(rd), 32'(m_rd));
                chk("rnd_Rd", Rd, m_Rd);
            end

            // Model the edge at the end of this cycle.
            if (rst) begin
                nb = m_busy;
                if (m_wen) nb[m_rd] = 1'b0;
                if (claim_en && claim_addr != 0) nb[claim_addr] = 1'b1;
                m_busy = nb;
                if (g0 || g1) begin
                    m_rd    = g1 ? req1_addr : req0_addr;
                    m_Rd    = g1 ? req1_data : req0_data;
                    m_wen   = (m_rd != 0);
                    m_last1 = g1;
                end else begin
                    m_wen = 1'b0;
                end
            end
        end
        $display("random: %0d cycles applied", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
